// File: rtl/dp_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dp_ram_be                                                    |
// | Description : Simple dual-port RAM with byte-enable writes, power-up clear |
// |               sequencer and optional output register.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module dp_ram_be #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       init_done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  localparam logic [0:0] c_st_init  = 1'b0;
  localparam logic [0:0] c_st_ready = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_same_addr;
  logic [DATA_WIDTH-1:0] w_mem_word;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  r_s1_vld;
  logic [DATA_WIDTH-1:0] r_s1_data;

  assign w_ready     = (r_state == c_st_ready);
  assign w_wr_acc    = w_ready & wr_en;
  assign w_rd_acc    = w_ready & rd_en;
  assign w_same_addr = (wr_addr == rd_addr);
  assign w_mem_word  = r_mem[rd_addr];
  assign init_done   = w_ready;

  // Clear sequencer: walks every address once after reset, then hands over to users.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= c_st_init;
      r_clr_cnt <= '0;
    end else if (r_state == c_st_init) begin
      r_clr_cnt <= r_clr_cnt + c_addr_one;
      if (r_clr_cnt == c_last_addr) begin
        r_state <= c_st_ready;
      end
    end
  end

  // Storage has no reset of its own; the sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == c_st_init)) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (rst_n && w_wr_acc) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) begin
          r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  generate
    if (RDW_MODE != 0) begin : g_rdw_new
      for (genvar b = 0; b < NUM_BYTES; b++) begin : g_merge
        assign w_rd_word[8*b +: 8] = (w_wr_acc && w_same_addr && wr_be[b]) ?
                                     wr_data[8*b +: 8] : w_mem_word[8*b +: 8];
      end
    end else begin : g_rdw_old
      assign w_rd_word = w_mem_word;
    end
  endgenerate

  // Data registers only load on an accepted read so rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_vld;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s2_vld  <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rd_data  = r_s2_data;
      assign rd_valid = r_s2_vld;
    end else begin : g_no_out_reg
      assign rd_data  = r_s1_data;
      assign rd_valid = r_s1_vld;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dp_ram_be                                                 |
// | Description : Self-checking bench for dp_ram_be (directed table + random). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_dp_ram_be;

  localparam int DW       = 16;
  localparam int AW       = 3;
  localparam int NB       = DW / 8;
  localparam int DEPTH    = 2 ** AW;
  localparam int OUT_REG  = 0;
  localparam int RDW_MODE = 0;
  localparam int LAT      = (OUT_REG != 0) ? 2 : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          init_done;

  dp_ram_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(OUT_REG), .RDW_MODE(RDW_MODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          tchk;
    logic [DW-1:0] tval;
  } pend_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            m_cnt = 0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_last = '0;
  pend_t         pend [$];
  vec_t          tbl [14];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [DW-1:0] apply(logic [DW-1:0] old, logic [DW-1:0] wd,
                                          logic [NB-1:0] be);
    logic [DW-1:0] r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One clock: drive, let the edge happen, advance the reference, then compare.
  task automatic step(input logic rn, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [NB-1:0] be, input logic re,
                      input logic [AW-1:0] ra, input logic tchk, input logic [DW-1:0] tval);
    logic [DW-1:0] word;
    pend_t         e;
    logic          exp_v;
    rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      m_last  = '0;
      pend.delete();
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_ready = 1'b1;
    end else begin
      if (re) begin
        word = m_mem[ra];
        if (RDW_MODE != 0 && we && wa == ra) word = apply(word, wd, be);
        pend.push_back('{cyc + LAT - 1, word, tchk, tval});
      end
      if (we) m_mem[wa] = apply(m_mem[wa], wd, be);
    end
    #1;
    check("init_done", {31'd0, init_done}, {31'd0, m_ready});
    exp_v = (pend.size() > 0) && (pend[0].due == cyc);
    check("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      e = pend.pop_front();
      m_last = e.data;
      check("rd_data", {16'd0, rd_data}, {16'd0, e.data});
      if (e.tchk) check("table_data", {16'd0, rd_data}, {16'd0, e.tval});
    end else begin
      check("rd_hold", {16'd0, rd_data}, {16'd0, m_last});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rn);
    step(rn, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1, a, 1'b1, exp);
  endtask

  task automatic wait_init(input logic we, input logic re);
    int n = 0;
    while (!init_done && n < 4 * DEPTH) begin
      step(1'b1, we, 3'd2, 16'hFFFF, 2'b11, re, 3'(n), 1'b0, '0);
      n++;
    end
    check("init_cycles", n, DEPTH);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, 3'd0, 16'h0000};
    tbl[1]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 16'hABCD};
    tbl[2]  = '{1'b1, 3'd3, 16'h1234, 2'b01, 1'b0, 3'd0, 16'h0000};
    tbl[3]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 16'hAB34};
    tbl[4]  = '{1'b1, 3'd3, 16'hFFFF, 2'b00, 1'b0, 3'd0, 16'h0000};
    tbl[5]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 16'hAB34};
    tbl[6]  = '{1'b1, 3'd5, 16'h1111, 2'b11, 1'b0, 3'd0, 16'h0000};
    tbl[7]  = '{1'b1, 3'd5, 16'h2222, 2'b11, 1'b1, 3'd5,
                (RDW_MODE != 0) ? 16'h2222 : 16'h1111};
    tbl[8]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5, 16'h2222};
    tbl[9]  = '{1'b1, 3'd6, 16'h5AA5, 2'b10, 1'b1, 3'd5, 16'h2222};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd6, 16'h5A00};
    tbl[11] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd3, 16'hAB34};
    tbl[12] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd0, 16'h0000};
    tbl[13] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd7, 16'h0000};

    // Reset with requests active, then user traffic during the clear is ignored.
    step(1'b0, 1'b1, 3'd1, 16'hDEAD, 2'b11, 1'b1, 3'd1, 1'b0, '0);
    idle(1'b0);
    wait_init(1'b1, 1'b1);
    for (int a = 0; a < DEPTH; a++) rd(3'(a), 16'h0000);
    repeat (LAT) idle(1'b1);

    for (int i = 0; i < 14; i++)
      step(1'b1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra,
           tbl[i].re, tbl[i].exp);
    repeat (LAT + 1) idle(1'b1);

    // Reset right behind an accepted read, then confirm the memory is re-cleared.
    step(1'b1, 1'b1, 3'd3, 16'hABCD, 2'b11, 1'b0, '0, 1'b0, '0);
    rd(3'd3, 16'hABCD);
    idle(1'b0);
    idle(1'b0);
    wait_init(1'b0, 1'b0);
    rd(3'd3, 16'h0000);
    repeat (LAT) idle(1'b1);

    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 199) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
           2'($urandom), 1'($urandom), 3'($urandom), 1'b0, '0);
    repeat (LAT + 1) idle(1'b1);
    check("drain", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
